// File: rtl/config_bus_pkg.sv
// Shared definitions for the tile configuration bus and its stream loader.
package config_bus_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned REC_W   = ADDR_W + DATA_W;
   localparam int unsigned COUNT_W = 16;

   localparam int unsigned TYPE_MSB = 31;
   localparam int unsigned TYPE_LSB = 16;
   localparam int unsigned TILE_MSB = 15;
   localparam int unsigned TILE_LSB = 0;

   localparam logic [15:0] CONFIG_SB        = 16'd7;
   localparam logic [15:0] CONFIG_CB0       = 16'd6;
   localparam logic [15:0] CONFIG_CB1       = 16'd5;
   localparam logic [15:0] CONFIG_CLB       = 16'd4;
   localparam logic [15:0] CONFIG_TYPE_IDLE = 16'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_REC,
      ST_ISSUE,
      ST_FINISH
   } loader_state_t;

   // Record layout as it arrives on the wire: address in the low word.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
   } config_rec_t;

   function automatic logic [15:0] addr_type(input logic [ADDR_W-1:0] a);
      return a[TYPE_MSB:TYPE_LSB];
   endfunction

   function automatic logic [15:0] addr_tile(input logic [ADDR_W-1:0] a);
      return a[TILE_MSB:TILE_LSB];
   endfunction

endpackage

// File: rtl/config_stream_loader_if.sv
// Byte stream in, configuration bus out; slave is the loader side.
interface config_stream_loader_if;
   import config_bus_pkg::*;

   logic [BYTE_W-1:0] byte_data;
   logic              byte_valid;
   logic              byte_ready;
   logic [ADDR_W-1:0] config_addr;
   logic [DATA_W-1:0] config_data;

   modport master (
      output byte_data, byte_valid,
      input  byte_ready, config_addr, config_data
   );

   modport slave (
      input  byte_data, byte_valid,
      output byte_ready, config_addr, config_data
   );
endinterface

// File: rtl/byte_assembler.sv
// Collects eight little-endian bytes into one address/data record.
module byte_assembler
   import config_bus_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              accept,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              rec_done_c,
   output config_rec_t       rec_next_c
);

   localparam int unsigned SHIFT_W = REC_W - BYTE_W;

   logic [2:0]         byte_idx;
   logic [SHIFT_W-1:0] shift;
   logic [REC_W-1:0]   rec_flat_c;

   // New bytes enter at the top so the first byte lands in bits [7:0].
   assign rec_flat_c = {byte_data, shift};
   assign rec_next_c = config_rec_t'(rec_flat_c);
   assign rec_done_c = accept && (byte_idx == 3'd7);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_idx <= '0;
         shift    <= '0;
      end else if (clear) begin
         byte_idx <= '0;
      end else if (accept) begin
         byte_idx <= byte_idx + 3'd1;
         shift    <= rec_flat_c[REC_W-1:BYTE_W];
      end
   end

endmodule

// File: rtl/config_stream_loader.sv
// Parses a counted byte stream of address/data records and drives the tile
// configuration bus, parking it on IDLE_ADDR whenever no record is issued.
module config_stream_loader
   import config_bus_pkg::*;
#(
   parameter int unsigned       ISSUE_CYCLES = 1,
   parameter logic [ADDR_W-1:0] IDLE_ADDR    = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   config_stream_loader_if.slave  bus,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_W-1:0]     records_loaded
);

   localparam int unsigned        ISSUE_W    = 4;
   localparam logic [ISSUE_W-1:0] ISSUE_LAST = ISSUE_W'(ISSUE_CYCLES - 1);

   loader_state_t      state, state_nxt;
   logic               hdr_phase, hdr_phase_nxt;
   logic [BYTE_W-1:0]  hdr_lo, hdr_lo_nxt;
   logic [COUNT_W-1:0] count_n, count_nxt;
   logic [COUNT_W-1:0] rec_cnt_nxt, hdr_count_c, rec_inc_c;
   logic [ISSUE_W-1:0] issue_cnt, issue_nxt;
   logic [ADDR_W-1:0]  addr_q, addr_nxt;
   logic [DATA_W-1:0]  data_q, data_nxt;
   logic               ready_q, ready_nxt, busy_nxt, done_nxt;
   logic               xfer_c, asm_clear_c, asm_accept_c, rec_done_c;
   config_rec_t        rec_next_c;

   assign xfer_c       = bus.byte_valid && ready_q;
   assign asm_clear_c  = (state == ST_IDLE) || abort;
   assign asm_accept_c = xfer_c && (state == ST_REC);
   assign hdr_count_c  = {bus.byte_data, hdr_lo};
   assign rec_inc_c    = records_loaded + COUNT_W'(1);

   assign bus.byte_ready  = ready_q;
   assign bus.config_addr = addr_q;
   assign bus.config_data = data_q;

   byte_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (asm_clear_c),
      .accept     (asm_accept_c),
      .byte_data  (bus.byte_data),
      .rec_done_c (rec_done_c),
      .rec_next_c (rec_next_c)
   );

   // Next state and next registered outputs.
   always_comb begin
      state_nxt     = state;
      hdr_phase_nxt = hdr_phase;
      hdr_lo_nxt    = hdr_lo;
      count_nxt     = count_n;
      issue_nxt     = issue_cnt;
      rec_cnt_nxt   = records_loaded;
      addr_nxt      = IDLE_ADDR;
      data_nxt      = '0;

      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               state_nxt     = ST_HDR;
               hdr_phase_nxt = 1'b0;
               rec_cnt_nxt   = '0;
            end
         end
         ST_HDR: begin
            if (xfer_c) begin
               if (!hdr_phase) begin
                  hdr_lo_nxt    = bus.byte_data;
                  hdr_phase_nxt = 1'b1;
               end else begin
                  count_nxt = hdr_count_c;
                  state_nxt = (hdr_count_c == '0) ? ST_FINISH : ST_REC;
               end
            end
         end
         ST_REC: begin
            if (rec_done_c) begin
               state_nxt = ST_ISSUE;
               issue_nxt = '0;
               addr_nxt  = rec_next_c.addr;
               data_nxt  = rec_next_c.data;
            end
         end
         ST_ISSUE: begin
            addr_nxt = addr_q;
            data_nxt = data_q;
            if (issue_cnt == ISSUE_LAST) begin
               addr_nxt    = IDLE_ADDR;
               data_nxt    = '0;
               rec_cnt_nxt = rec_inc_c;
               state_nxt   = (rec_inc_c == count_n) ? ST_FINISH : ST_REC;
            end else begin
               issue_nxt = issue_cnt + ISSUE_W'(1);
            end
         end
         ST_FINISH: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase

      // Abort discards any in-flight record without counting it.
      if (abort && (state != ST_IDLE)) begin
         state_nxt   = ST_IDLE;
         addr_nxt    = IDLE_ADDR;
         data_nxt    = '0;
         rec_cnt_nxt = records_loaded;
      end

      done_nxt  = (state_nxt == ST_FINISH);
      busy_nxt  = (state_nxt == ST_HDR) || (state_nxt == ST_REC) || (state_nxt == ST_ISSUE);
      ready_nxt = (state_nxt == ST_HDR) || (state_nxt == ST_REC);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_IDLE;
         hdr_phase      <= 1'b0;
         hdr_lo         <= '0;
         count_n        <= '0;
         issue_cnt      <= '0;
         records_loaded <= '0;
         addr_q         <= IDLE_ADDR;
         data_q         <= '0;
         ready_q        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_nxt;
         hdr_phase      <= hdr_phase_nxt;
         hdr_lo         <= hdr_lo_nxt;
         count_n        <= count_nxt;
         issue_cnt      <= issue_nxt;
         records_loaded <= rec_cnt_nxt;
         addr_q         <= addr_nxt;
         data_q         <= data_nxt;
         ready_q        <= ready_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
      end
   end

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader at ISSUE_CYCLES of 1, 3 and 4.
module tb_config_stream_loader;
   import config_bus_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [7:0]  byte_data;
   logic        byte_valid;
   int          sel;

   logic        busy1, busy3, busy4, done1, done3, done4;
   logic [15:0] rl1, rl3, rl4;

   logic        ready_m, busy_m, done_m;
   logic [31:0] addr_m, data_m;
   logic [15:0] rl_m;

   int          checks;
   int          errors;
   int          cyc;
   int          done_cnt;
   int          done_cyc;
   int          sb3_cnt;
   int          other3_cnt;
   int          ready_in_issue;
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   int          log_cyc[$];

   config_stream_loader_if if1 ();
   config_stream_loader_if if3 ();
   config_stream_loader_if if4 ();

   assign if1.byte_data  = byte_data;
   assign if3.byte_data  = byte_data;
   assign if4.byte_data  = byte_data;
   assign if1.byte_valid = byte_valid && (sel == 0);
   assign if3.byte_valid = byte_valid && (sel == 1);
   assign if4.byte_valid = byte_valid && (sel == 2);

   config_stream_loader #(.ISSUE_CYCLES(1), .IDLE_ADDR(32'h0000_0000)) u1 (
      .clk(clk), .reset(rst_n), .start(start && (sel == 0)), .abort(abort && (sel == 0)),
      .bus(if1), .busy(busy1), .done(done1), .records_loaded(rl1));
   config_stream_loader #(.ISSUE_CYCLES(3), .IDLE_ADDR(32'h0000_0000)) u3 (
      .clk(clk), .reset(rst_n), .start(start && (sel == 1)), .abort(abort && (sel == 1)),
      .bus(if3), .busy(busy3), .done(done3), .records_loaded(rl3));
   config_stream_loader #(.ISSUE_CYCLES(4), .IDLE_ADDR(32'h0000_0000)) u4 (
      .clk(clk), .reset(rst_n), .start(start && (sel == 2)), .abort(abort && (sel == 2)),
      .bus(if4), .busy(busy4), .done(done4), .records_loaded(rl4));

   always_comb begin
      ready_m = if1.byte_ready; addr_m = if1.config_addr; data_m = if1.config_data;
      busy_m  = busy1; done_m = done1; rl_m = rl1;
      if (sel == 1) begin
         ready_m = if3.byte_ready; addr_m = if3.config_addr; data_m = if3.config_data;
         busy_m  = busy3; done_m = done3; rl_m = rl3;
      end else if (sel == 2) begin
         ready_m = if4.byte_ready; addr_m = if4.config_addr; data_m = if4.config_data;
         busy_m  = busy4; done_m = done4; rl_m = rl4;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus observer on the selected loader, including a tile-3 enable decoder.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (addr_m !== 32'h0 || data_m !== 32'h0) begin
         log_addr.push_back(addr_m);
         log_data.push_back(data_m);
         log_cyc.push_back(cyc);
         if (ready_m) ready_in_issue = ready_in_issue + 1;
      end
      if (done_m === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (addr_tile(addr_m) == 16'd3) begin
         if (addr_type(addr_m) == CONFIG_SB) sb3_cnt = sb3_cnt + 1;
         else if (addr_type(addr_m) == CONFIG_CB0 || addr_type(addr_m) == CONFIG_CB1 ||
                  addr_type(addr_m) == CONFIG_CLB) other3_cnt = other3_cnt + 1;
      end
   end

   task automatic clear_obs();
      log_addr.delete(); log_data.delete(); log_cyc.delete();
      done_cnt = 0; sb3_cnt = 0; other3_cnt = 0; ready_in_issue = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b, input int max_gap);
      int  gap;
      int  n;
      logic took;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin byte_valid = 1'b0; @(posedge clk); #1; end
      byte_data  = b;
      byte_valid = 1'b1;
      n = 0; took = 1'b0;
      while (!took && n < 40) begin
         @(negedge clk); took = ready_m;
         @(posedge clk); #1; n++;
      end
      if (!took) begin
         checks++; errors++;
         $display("FAIL byte_accept_timeout byte=%h ready=%b required=1", b, ready_m);
      end
   endtask

   task automatic push_word(input logic [31:0] w, input int max_gap);
      for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8], max_gap);
   endtask

   task automatic test_reset();
      sel = 0; byte_valid = 1'b1; byte_data = 8'hA5; rst_n = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if (addr_m !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=00000000", addr_m); end
      checks++; if (addr_type(addr_m) !== CONFIG_TYPE_IDLE) begin errors++; $display("FAIL reset_type got=%h exp=0000", addr_type(addr_m)); end
      checks++; if (data_m !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=00000000", data_m); end
      checks++; if (ready_m !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_m); end
      checks++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy_m, done_m); end
      checks++; if (rl_m !== 16'h0) begin errors++; $display("FAIL reset_records got=%0d exp=0", rl_m); end
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++; if (ready_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL idle_no_start ready=%b busy=%b exp=0 0", ready_m, busy_m); end
      end
      byte_valid = 1'b0;
   endtask

   task automatic test_single();
      int mark;
      sel = 0; clear_obs();
      pulse_start();
      checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy_m); end
      push_byte(8'h01, 0); push_byte(8'h00, 0);
      push_word(32'h0007_0003, 0); push_word(32'h0000_0005, 0);
      mark = cyc;
      byte_valid = 1'b0;
      repeat (4) @(posedge clk); #1;
      checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL single_issue_count got=%0d exp=1", log_addr.size()); end
      else begin
         checks++; if (log_addr[0] !== 32'h0007_0003) begin errors++; $display("FAIL single_addr got=%h exp=00070003", log_addr[0]); end
         checks++; if (log_data[0] !== 32'h5) begin errors++; $display("FAIL single_data got=%h exp=00000005", log_data[0]); end
         checks++; if (log_cyc[0] !== mark + 1) begin errors++; $display("FAIL single_issue_cycle got=%0d exp=%0d", log_cyc[0], mark + 1); end
      end
      checks++; if (done_cnt !== 1 || done_cyc !== mark + 2) begin errors++; $display("FAIL single_done cnt=%0d cyc=%0d exp=1 %0d", done_cnt, done_cyc, mark + 2); end
      checks++; if (rl_m !== 16'd1) begin errors++; $display("FAIL single_records got=%0d exp=1", rl_m); end
      checks++; if (sb3_cnt !== 1 || other3_cnt !== 0) begin errors++; $display("FAIL single_tile3_sb sb=%0d other=%0d exp=1 0", sb3_cnt, other3_cnt); end
      checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy_m); end
   endtask

   task automatic test_three_gaps();
      logic [31:0] ea[3];
      logic [31:0] ed[3];
      ea[0] = 32'h0006_0001; ed[0] = 32'hDEAD_BEEF;
      ea[1] = 32'h0005_0002; ed[1] = 32'h1234_5678;
      ea[2] = 32'h0004_0003; ed[2] = 32'hA5A5_0F0F;
      sel = 1; clear_obs();
      pulse_start();
      push_byte(8'h03, 2); push_byte(8'h00, 2);
      for (int r = 0; r < 3; r++) begin push_word(ea[r], 2); push_word(ed[r], 2); end
      byte_valid = 1'b0;
      repeat (8) @(posedge clk); #1;
      checks++; if (log_addr.size() !== 9) begin errors++; $display("FAIL three_issue_cycles got=%0d exp=9", log_addr.size()); end
      else begin
         for (int k = 0; k < 9; k++) begin
            checks++;
            if (log_addr[k] !== ea[k/3] || log_data[k] !== ed[k/3] || log_cyc[k] !== log_cyc[(k/3)*3] + (k%3)) begin
               errors++; $display("FAIL three_beat%0d got=%h/%h@%0d exp=%h/%h", k, log_addr[k], log_data[k], log_cyc[k], ea[k/3], ed[k/3]);
            end
         end
         checks++; if (log_cyc[3] - log_cyc[2] < 9 || log_cyc[6] - log_cyc[5] < 9) begin errors++; $display("FAIL three_idle_between gaps=%0d %0d exp>=9", log_cyc[3] - log_cyc[2], log_cyc[6] - log_cyc[5]); end
      end
      checks++; if (ready_in_issue !== 0) begin errors++; $display("FAIL three_ready_in_issue got=%0d exp=0", ready_in_issue); end
      checks++; if (rl_m !== 16'd3) begin errors++; $display("FAIL three_records got=%0d exp=3", rl_m); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL three_done got=%0d exp=1", done_cnt); end
      checks++; if (sb3_cnt !== 0 || other3_cnt !== 3) begin errors++; $display("FAIL three_tile3 sb=%0d other=%0d exp=0 3", sb3_cnt, other3_cnt); end
   endtask

   task automatic test_zero_count();
      int mark;
      sel = 0; clear_obs();
      pulse_start();
      push_byte(8'h00, 0); push_byte(8'h00, 0);
      mark = cyc;
      byte_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL zero_issue got=%0d exp=0", log_addr.size()); end
      checks++; if (done_cnt !== 1 || done_cyc !== mark + 1) begin errors++; $display("FAIL zero_done cnt=%0d cyc=%0d exp=1 %0d", done_cnt, done_cyc, mark + 1); end
      checks++; if (rl_m !== 16'd0) begin errors++; $display("FAIL zero_records got=%0d exp=0", rl_m); end
   endtask

   task automatic test_abort();
      sel = 0; clear_obs();
      pulse_start();
      push_byte(8'h04, 0); push_byte(8'h00, 0);
      push_word(32'h0004_0005, 0); push_word(32'h0000_0011, 0);
      push_word(32'h0007_0003, 0); push_byte(8'h99, 0);
      abort = 1'b1; byte_valid = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++; if (busy_m !== 1'b0 || ready_m !== 1'b0) begin errors++; $display("FAIL abort_busy busy=%b ready=%b exp=0 0", busy_m, ready_m); end
      repeat (15) @(posedge clk); #1;
      checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL abort_issue_count got=%0d exp=1", log_addr.size()); end
      else begin
         checks++; if (log_addr[0] !== 32'h0004_0005) begin errors++; $display("FAIL abort_first_addr got=%h exp=00040005", log_addr[0]); end
      end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
      checks++; if (rl_m !== 16'd1) begin errors++; $display("FAIL abort_records got=%0d exp=1", rl_m); end
      // abort and start together in IDLE
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      checks++; if (busy_m !== 1'b0 || ready_m !== 1'b0) begin errors++; $display("FAIL abort_start_idle busy=%b ready=%b exp=0 0", busy_m, ready_m); end
      clear_obs();
      pulse_start();
      push_byte(8'h01, 0); push_byte(8'h00, 0);
      push_word(32'h0006_0002, 0); push_word(32'h0000_0077, 0);
      byte_valid = 1'b0;
      repeat (4) @(posedge clk); #1;
      checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL reload_issue_count got=%0d exp=1", log_addr.size()); end
      else begin
         checks++; if (log_addr[0] !== 32'h0006_0002 || log_data[0] !== 32'h77) begin errors++; $display("FAIL reload_record got=%h/%h exp=00060002/00000077", log_addr[0], log_data[0]); end
      end
      checks++; if (done_cnt !== 1 || rl_m !== 16'd1) begin errors++; $display("FAIL reload_done done=%0d records=%0d exp=1 1", done_cnt, rl_m); end
   endtask

   task automatic test_async_reset();
      sel = 2; clear_obs();
      pulse_start();
      push_byte(8'h02, 0); push_byte(8'h00, 0);
      push_word(32'h0007_0009, 0); push_word(32'hCAFE_0001, 0);
      byte_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (addr_m !== 32'h0007_0009) begin errors++; $display("FAIL areset_pre_addr got=%h exp=00070009", addr_m); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (addr_m !== 32'h0 || data_m !== 32'h0) begin errors++; $display("FAIL areset_bus got=%h/%h exp=0/0", addr_m, data_m); end
      checks++; if (ready_m !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0) begin errors++; $display("FAIL areset_ctrl got=%b%b%b exp=000", ready_m, busy_m, done_m); end
      checks++; if (rl_m !== 16'd0) begin errors++; $display("FAIL areset_records got=%0d exp=0", rl_m); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      done_cnt = 0; done_cyc = 0; sb3_cnt = 0; other3_cnt = 0; ready_in_issue = 0;
      start = 1'b0; abort = 1'b0; byte_data = 8'h00; byte_valid = 1'b0; sel = 0; rst_n = 1'b0;
      test_reset();
      test_single();
      test_three_gaps();
      test_zero_count();
      test_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Upstream feeder of the tile configuration bus; the only driver of config_addr / config_data into the PE tile array.
- Accepts a byte stream (valid/ready) from the host interface (UART/SPI front end).
- Parses a length header plus N address/data records and issues one config write per record.
- Between writes it parks the bus on a non-matching idle address, so no tile's SB/CB/CLB enable asserts spuriously.

Parameters:
- ISSUE_CYCLES, 1, cycles each record's addr/data is held on the bus; legal range 1..15.
- IDLE_ADDR, 32'h0000_0000, bus address when not issuing; type field 0 is reserved, so it matches no tile.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE.
- abort  input  1  synchronous; abandons the current load.
- byte_data  input  8  stream byte.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- config_addr  output  32  {type[31:16], tile_id[15:0]} to all tiles.
- config_data  output  32  configuration payload to all tiles.
- busy  output  1  high from the accepted start until the return to IDLE.
- done  output  1  one-cycle pulse on successful completion.
- records_loaded  output  16  records issued in the current or last load.

Behaviour:
- Reset (reset=0, async) values:
  - config_addr=IDLE_ADDR, config_data=0.
  - byte_ready=0, busy=0, done=0, records_loaded=0.
  - State IDLE.
- Byte handshake: a byte transfers on a rising clk edge when byte_valid && byte_ready. byte_ready is a registered function of state only, never of byte_valid.
- Stream format, little-endian throughout:
  - 2 header bytes giving count N.
  - Then N records of 8 bytes: addr[7:0] .. addr[31:24], then data[7:0] .. data[31:24].
- States:
  - IDLE: byte_ready=0. start → HDR; records_loaded cleared; busy=1 next cycle.
  - HDR: byte_ready=1. Collects 2 bytes. After the 2nd: N==0 → FINISH, else → REC.
  - REC: byte_ready=1. 3-bit byte index plus 64-bit shift register. After the 8th byte is accepted (edge t) → ISSUE.
  - ISSUE: byte_ready=0. config_addr/config_data carry the assembled record in cycles t+1 .. t+ISSUE_CYCLES. records_loaded increments at the end of the final ISSUE cycle. Then, if records_loaded == N → FINISH, else → REC.
  - Leaving ISSUE: config_addr returns to IDLE_ADDR and config_data to 0 in the very next cycle.
  - FINISH: done=1 for exactly one cycle; busy=0 in that cycle; next state IDLE.
- Outside ISSUE, config_addr==IDLE_ADDR and config_data==0 at all times.
- Record throughput: at best one record per 8+ISSUE_CYCLES cycles.
- start while busy: ignored, no effect.
- byte_valid in IDLE: not accepted, since byte_ready=0.
- abort, any non-IDLE state:
  - Next cycle: state IDLE, bus idle, busy=0, done=0.
  - records_loaded keeps the count of records already issued.
  - A partially assembled record is discarded, never issued.
- abort and start in the same cycle in IDLE: abort wins, so the loader stays IDLE.
- Async reset mid-ISSUE: bus drops to IDLE_ADDR immediately (asynchronously), with no write completed.
- N=65535: the 16-bit counter compares for equality, so there is no wrap.
- The loader never inspects addresses. A record whose address equals IDLE_ADDR is issued as-is (a harmless no-op).

Decomposition:
- Shared package config_bus_pkg holds:
  - CONFIG_SB=7, CONFIG_CB0=6, CONFIG_CB1=5, CONFIG_CLB=4.
  - CONFIG_TYPE_IDLE=0.
  - Address field slices (type [31:16], tile [15:0]).
  - Loader state encoding.
- One natural sub-module: byte_assembler, an 8→64 shift/collect unit with byte index and "record complete" flag. Header parsing and the FSM stay in the top.

Test Plan:
- Reset: hold reset=0 with byte_valid=1 → config_addr=0x0000_0000, byte_ready=0, busy=0. Release reset, no start → byte_ready stays 0.
- Single record: start, N=1, record addr=0x0007_0003, data=0x0000_0005, byte_valid held high.
  - config_addr=0x0007_0003 / config_data=5 for exactly 1 cycle, one cycle after the 8th byte.
  - done pulses 1 cycle after that; records_loaded=1.
  - A tile with id 3 sees config_en_sb for exactly 1 cycle.
- Three records with random byte_valid gaps, ISSUE_CYCLES=3:
  - Each record is driven for exactly 3 cycles, in order.
  - byte_ready=0 during every ISSUE cycle.
  - Bus idle between records; records_loaded=3.
- N=0: header bytes 0x00,0x00 → no issue cycle; done pulses the cycle after the 2nd header byte.
- Abort after 5 bytes of record 2 (N=4) → no 2nd write; busy=0 next cycle; done never pulses; records_loaded=1. A new start then loads normally.
- Async reset mid-ISSUE with ISSUE_CYCLES=4, reset asserted in the 2nd issue cycle → config_addr=IDLE_ADDR before the next clk edge; all outputs at reset values.
